// File: rtl/rob_if.sv
// Reorder buffer port bundle: allocate, writeback, commit and flush/status signals.
// The ROB takes the slave side; the pipeline or bench drives the master side.
interface rob_if #(
    parameter int NUM_ENTRIES = 32,
    parameter int NUM_WB      = 3,
    parameter int DATA_W      = 32
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic                     alloc_req_i;
    logic [4:0]               alloc_prd_i;
    logic [31:0]              alloc_pc_i;
    logic [31:0]              alloc_inst_i;
    logic [IDX_W-1:0]         alloc_idx_o;

    logic [NUM_WB-1:0]        wb_valid_i;
    logic [NUM_WB*IDX_W-1:0]  wb_idx_i;
    logic [NUM_WB*DATA_W-1:0] wb_value_i;
    logic [NUM_WB-1:0]        wb_exc_i;

    logic                     commit_ready_i;
    logic                     commit_valid_o;
    logic [31:0]              commit_pc_o;
    logic [31:0]              commit_inst_o;
    logic [4:0]               commit_prd_o;
    logic [DATA_W-1:0]        commit_value_o;
    logic                     commit_exc_o;

    logic                     flush_i;
    logic                     flush_o;
    logic                     empty_o;
    logic                     full_o;
    logic [IDX_W:0]           count_o;

    modport slave (
        input  alloc_req_i, alloc_prd_i, alloc_pc_i, alloc_inst_i,
        input  wb_valid_i, wb_idx_i, wb_value_i, wb_exc_i,
        input  commit_ready_i, flush_i,
        output alloc_idx_o, commit_valid_o, commit_pc_o, commit_inst_o,
        output commit_prd_o, commit_value_o, commit_exc_o,
        output flush_o, empty_o, full_o, count_o
    );

    modport master (
        output alloc_req_i, alloc_prd_i, alloc_pc_i, alloc_inst_i,
        output wb_valid_i, wb_idx_i, wb_value_i, wb_exc_i,
        output commit_ready_i, flush_i,
        input  alloc_idx_o, commit_valid_o, commit_pc_o, commit_inst_o,
        input  commit_prd_o, commit_value_o, commit_exc_o,
        input  flush_o, empty_o, full_o, count_o
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: circular queue with wrap-bit pointers,
// NUM_WB out-of-order writeback ports, and exception-triggered self flush.

// Per writeback port: decides whether the target index is currently live.
module rob_wb_lane #(
    parameter int IDX_W = 5
) (
    input  logic             valid,
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] head_idx,
    input  logic [IDX_W:0]   count,
    output logic             hit
);
    logic [IDX_W-1:0] off;

    // Distance from head modulo depth; live iff it falls inside occupancy.
    assign off = idx - head_idx;
    assign hit = valid && ({1'b0, off} < count);
endmodule

module reorder_buffer #(
    parameter int NUM_ENTRIES = 32,
    parameter int NUM_WB      = 3,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic clk_i,
    input  logic reset_i,
    rob_if.slave rob
);
    typedef logic [IDX_W:0] ptr_t;

    ptr_t                           head, tail, count;
    logic [IDX_W-1:0]               head_idx, tail_idx;
    logic [NUM_ENTRIES-1:0]         done_q, exc_q;
    logic                           flush_q;

    logic [4:0]                     prd_mem  [NUM_ENTRIES];
    logic [31:0]                    pc_mem   [NUM_ENTRIES];
    logic [31:0]                    inst_mem [NUM_ENTRIES];
    logic [DATA_W-1:0]              val_mem  [NUM_ENTRIES];

    logic [NUM_WB-1:0][IDX_W-1:0]   wb_idx;
    logic [NUM_WB-1:0][DATA_W-1:0]  wb_val;
    logic [NUM_WB-1:0]              wb_hit;

    logic empty, full, alloc_fire, commit_valid, commit_fire, exc_flush, flush_all;

    assign wb_idx   = rob.wb_idx_i;
    assign wb_val   = rob.wb_value_i;
    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign count    = tail - head;

    assign empty        = (head == tail);
    assign full         = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    assign alloc_fire   = rob.alloc_req_i && !full;
    assign commit_valid = !empty && done_q[head_idx];
    assign commit_fire  = commit_valid && rob.commit_ready_i;
    assign exc_flush    = commit_fire && exc_q[head_idx];
    assign flush_all    = rob.flush_i || exc_flush;

    for (genvar p = 0; p < NUM_WB; p++) begin : g_lane
        rob_wb_lane #(.IDX_W(IDX_W)) u_lane (
            .valid    (rob.wb_valid_i[p]),
            .idx      (wb_idx[p]),
            .head_idx (head_idx),
            .count    (count),
            .hit      (wb_hit[p])
        );
    end

    // Control state; later ports overwrite earlier ones on a shared index.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head    <= '0;
            tail    <= '0;
            done_q  <= '0;
            exc_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= exc_flush;
            if (flush_all) begin
                head   <= '0;
                tail   <= '0;
                done_q <= '0;
                exc_q  <= '0;
            end else begin
                if (alloc_fire) begin
                    tail             <= tail + ptr_t'(1);
                    done_q[tail_idx] <= 1'b0;
                    exc_q[tail_idx]  <= 1'b0;
                end
                for (int p = 0; p < NUM_WB; p++) begin
                    if (wb_hit[p]) begin
                        done_q[wb_idx[p]] <= 1'b1;
                        exc_q[wb_idx[p]]  <= rob.wb_exc_i[p];
                    end
                end
                if (commit_fire) head <= head + ptr_t'(1);
            end
        end
    end

    // Payload storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (alloc_fire && !flush_all) begin
            prd_mem[tail_idx]  <= rob.alloc_prd_i;
            pc_mem[tail_idx]   <= rob.alloc_pc_i;
            inst_mem[tail_idx] <= rob.alloc_inst_i;
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_hit[p] && !flush_all) val_mem[wb_idx[p]] <= wb_val[p];
        end
    end

    assign rob.alloc_idx_o    = tail_idx;
    assign rob.commit_valid_o = commit_valid;
    assign rob.commit_pc_o    = commit_valid ? pc_mem[head_idx]   : '0;
    assign rob.commit_inst_o  = commit_valid ? inst_mem[head_idx] : '0;
    assign rob.commit_prd_o   = commit_valid ? prd_mem[head_idx]  : '0;
    assign rob.commit_value_o = commit_valid ? val_mem[head_idx]  : '0;
    assign rob.commit_exc_o   = commit_valid && exc_q[head_idx];
    assign rob.flush_o        = flush_q;
    assign rob.empty_o        = empty;
    assign rob.full_o         = full;
    assign rob.count_o        = count;
endmodule

// File: tb/tb_reorder_buffer.sv
// Random + directed bench for reorder_buffer against a queue-based ROB model.
module tb_reorder_buffer;
  localparam int N  = 32;
  localparam int NW = 3;
  localparam int DW = 32;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rob_if #(.NUM_ENTRIES(N), .NUM_WB(NW), .DATA_W(DW)) bus ();

  reorder_buffer #(.NUM_ENTRIES(N), .NUM_WB(NW), .DATA_W(DW)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .rob     (bus.slave)
  );

  typedef struct {
    logic [4:0]    prd;
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic [DW-1:0] value;
    bit            done;
    bit            exc;
  } ent_t;

  ent_t          q[$];
  int            m_head = 0;
  bit            m_flush = 1'b0;
  logic [31:0]   obs_pc[$];
  logic [DW-1:0] obs_val[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    bus.alloc_req_i    = 1'b0;
    bus.alloc_prd_i    = '0;
    bus.alloc_pc_i     = '0;
    bus.alloc_inst_i   = '0;
    bus.wb_valid_i     = '0;
    bus.wb_idx_i       = '0;
    bus.wb_value_i     = '0;
    bus.wb_exc_i       = '0;
    bus.commit_ready_i = 1'b0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic set_wb(input int p, input int idx, input logic [DW-1:0] val, input bit exc);
    bus.wb_valid_i[p]          = 1'b1;
    bus.wb_idx_i[p*IW +: IW]   = IW'(idx);
    bus.wb_value_i[p*DW +: DW] = val;
    bus.wb_exc_i[p]            = exc;
  endtask

  task automatic set_alloc(input logic [31:0] pc);
    bus.alloc_req_i  = 1'b1;
    bus.alloc_pc_i   = pc;
    bus.alloc_inst_i = $urandom;
    bus.alloc_prd_i  = 5'($urandom);
  endtask

  // Compare every output with the model, then advance model on the clock edge.
  task automatic check_outputs();
    int   sz = q.size();
    bit   v  = (sz > 0) && q[0].done;
    chk("empty", 64'(bus.empty_o), 64'(sz == 0));
    chk("full", 64'(bus.full_o), 64'(sz == N));
    chk("count", 64'(bus.count_o), 64'(sz));
    chk("alloc_idx", 64'(bus.alloc_idx_o), 64'((m_head + sz) % N));
    chk("commit_valid", 64'(bus.commit_valid_o), 64'(v));
    chk("commit_pc", 64'(bus.commit_pc_o), v ? 64'(q[0].pc) : 64'(0));
    chk("commit_inst", 64'(bus.commit_inst_o), v ? 64'(q[0].inst) : 64'(0));
    chk("commit_prd", 64'(bus.commit_prd_o), v ? 64'(q[0].prd) : 64'(0));
    chk("commit_value", 64'(bus.commit_value_o), v ? 64'(q[0].value) : 64'(0));
    chk("commit_exc", 64'(bus.commit_exc_o), v ? 64'(q[0].exc) : 64'(0));
    chk("flush_o", 64'(bus.flush_o), 64'(m_flush));
  endtask

  task automatic model_edge();
    int sz;
    bit fire, excf;
    if (rst) begin
      q.delete();
      m_head  = 0;
      m_flush = 1'b0;
      return;
    end
    sz   = q.size();
    fire = (sz > 0) && q[0].done && bus.commit_ready_i;
    excf = fire && q[0].exc;
    m_flush = excf;
    if (bus.flush_i || excf) begin
      q.delete();
      m_head = 0;
      return;
    end
    for (int p = 0; p < NW; p++) begin
      if (bus.wb_valid_i[p]) begin
        int pos = (int'(bus.wb_idx_i[p*IW +: IW]) - m_head + N) % N;
        if (pos < sz) begin
          q[pos].value = bus.wb_value_i[p*DW +: DW];
          q[pos].done  = 1'b1;
          q[pos].exc   = bus.wb_exc_i[p];
        end
      end
    end
    if (fire) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % N;
    end
    if (bus.alloc_req_i && sz < N) begin
      ent_t e;
      e.prd = bus.alloc_prd_i; e.pc = bus.alloc_pc_i; e.inst = bus.alloc_inst_i;
      e.value = '0; e.done = 1'b0; e.exc = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (bus.commit_valid_o && bus.commit_ready_i) begin
      obs_pc.push_back(bus.commit_pc_o);
      obs_val.push_back(bus.commit_value_o);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_empty", 64'(bus.empty_o), 64'(1));
    chk("rst_count", 64'(bus.count_o), 64'(0));

    // In-order commit despite out-of-order completion.
    for (int i = 0; i < 3; i++) begin
      clr(); set_alloc(32'h100 + 32'(4 * i)); step();
    end
    clr(); bus.commit_ready_i = 1'b1; set_wb(0, 2, 32'h22, 1'b0); step();
    chk("no_commit_before_head", 64'(bus.commit_valid_o), 64'(0));
    obs_pc.delete();
    clr(); bus.commit_ready_i = 1'b1; set_wb(1, 0, 32'h20, 1'b0); step();
    clr(); bus.commit_ready_i = 1'b1; set_wb(2, 1, 32'h21, 1'b0); step();
    clr(); bus.commit_ready_i = 1'b1; step();
    step();
    chk("order_n", 64'(obs_pc.size()), 64'(3));
    if (obs_pc.size() == 3) begin
      chk("order_0", 64'(obs_pc[0]), 64'h100);
      chk("order_1", 64'(obs_pc[1]), 64'h104);
      chk("order_2", 64'(obs_pc[2]), 64'h108);
    end

    // Fill, drop when full, wrap.
    do_reset();
    for (int i = 0; i < N; i++) begin
      clr(); set_alloc(32'h1000 + 32'(i)); step();
    end
    chk("fill_full", 64'(bus.full_o), 64'(1));
    chk("fill_count", 64'(bus.count_o), 64'(N));
    clr(); set_alloc(32'hdead); step();
    chk("drop_idx", 64'(bus.alloc_idx_o), 64'(0));
    chk("drop_count", 64'(bus.count_o), 64'(N));
    clr(); set_wb(0, 0, 32'h5, 1'b0); step();
    clr(); bus.commit_ready_i = 1'b1; set_alloc(32'hbeef); step();
    chk("same_cycle_no_admit", 64'(bus.count_o), 64'(N - 1));
    clr(); set_alloc(32'h2000); step();
    chk("wrap_full", 64'(bus.full_o), 64'(1));
    chk("wrap_idx", 64'(bus.alloc_idx_o), 64'(1));

    // Same-index writeback collision: higher port wins.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      clr(); set_alloc(32'h300 + 32'(i)); step();
    end
    clr(); set_wb(0, 5, 32'hAAAA, 1'b0); set_wb(2, 5, 32'hBBBB, 1'b0); step();
    obs_val.delete();
    for (int i = 0; i < 5; i++) begin
      clr(); bus.commit_ready_i = 1'b1; set_wb(1, i, 32'(i), 1'b0); step();
    end
    clr(); bus.commit_ready_i = 1'b1; step(); step();
    chk("collide_n", 64'(obs_val.size()), 64'(6));
    if (obs_val.size() == 6) chk("collide_val", 64'(obs_val[5]), 64'hBBBB);

    // Backpressure holds the head entry.
    do_reset();
    clr(); set_alloc(32'h400); step();
    clr(); set_wb(0, 0, 32'h77, 1'b0); step();
    obs_pc.delete();
    for (int i = 0; i < 4; i++) begin
      clr(); step();
      chk("hold_valid", 64'(bus.commit_valid_o), 64'(1));
      chk("hold_pc", 64'(bus.commit_pc_o), 64'h400);
    end
    clr(); bus.commit_ready_i = 1'b1; step(); step();
    chk("hold_one_commit", 64'(obs_pc.size()), 64'(1));

    // Exception commit flushes; external flush beats allocate.
    do_reset();
    clr(); set_alloc(32'h500); step();
    clr(); set_alloc(32'h504); step();
    clr(); set_wb(0, 0, 32'h1, 1'b1); set_wb(1, 1, 32'h2, 1'b0); step();
    chk("exc_presented", 64'(bus.commit_exc_o), 64'(1));
    clr(); bus.commit_ready_i = 1'b1; step();
    chk("exc_flush_pulse", 64'(bus.flush_o), 64'(1));
    chk("exc_empty", 64'(bus.empty_o), 64'(1));
    chk("exc_count", 64'(bus.count_o), 64'(0));
    clr(); step();
    chk("exc_flush_drop", 64'(bus.flush_o), 64'(0));
    clr(); set_alloc(32'h600); bus.flush_i = 1'b1; step();
    chk("flush_beats_alloc", 64'(bus.empty_o), 64'(1));

    // Reset discards live entries.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      clr(); set_alloc(32'h700 + 32'(i)); set_wb(0, 0, 32'h9, 1'b0); step();
    end
    clr(); rst = 1'b1; bus.commit_ready_i = 1'b1; set_alloc(32'h7ff); step();
    rst = 1'b0;
    chk("rst_live_empty", 64'(bus.empty_o), 64'(1));
    chk("rst_live_valid", 64'(bus.commit_valid_o), 64'(0));
    chk("rst_live_idx", 64'(bus.alloc_idx_o), 64'(0));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      clr();
      if ($urandom_range(9) < 6) set_alloc($urandom);
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(2) == 0) begin
          int idx;
          if (q.size() > 0 && $urandom_range(3) != 0)
            idx = (m_head + int'($urandom_range(q.size() - 1))) % N;
          else
            idx = int'($urandom_range(N - 1));
          set_wb(p, idx, $urandom, $urandom_range(19) == 0);
        end
      end
      bus.commit_ready_i = ($urandom_range(9) < 7);
      bus.flush_i        = ($urandom_range(59) == 0);
      rst                = ($urandom_range(149) == 0);
      step();
    end
    rst = 1'b0;
    clr();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 NUM_ENTRIES, 32: ROB depth; power of two, 4..64.
REQ-002 NUM_WB, 3: number of writeback ports.
REQ-003 DATA_W, 32: result width.
REQ-004 IDX_W, $clog2(NUM_ENTRIES): entry index width (derived).
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 reset_i  in  1  reset, synchronous, active-high.
REQ-007 alloc_req_i  in  1  allocate request.
REQ-008 alloc_prd_i  in  5  destination physical register.
REQ-009 alloc_pc_i / alloc_inst_i  in  32 each  PC and instruction of the allocated op.
REQ-010 alloc_idx_o  out  IDX_W  index the next allocation receives (tail).
REQ-011 wb_valid_i  in  NUM_WB  per-port writeback strobe.
REQ-012 wb_idx_i  in  NUM_WB*IDX_W  per-port target index, port p at bits [p*IDX_W +: IDX_W].
REQ-013 wb_value_i  in  NUM_WB*DATA_W  per-port result, packed the same way.
REQ-014 wb_exc_i  in  NUM_WB  per-port exception flag.
REQ-015 commit_ready_i  in  1  consumer accepts the head entry.
REQ-016 commit_valid_o  out  1  head entry complete and presented.
REQ-017 commit_pc_o, commit_inst_o (32), commit_prd_o (5), commit_value_o (DATA_W), commit_exc_o (1)  out  head entry fields.
REQ-018 flush_i  in  1  external pipeline flush.
REQ-019 flush_o  out  1  one-cycle pulse: exception entry committed.
REQ-020 empty_o, full_o  out  1 each; count_o  out  IDX_W+1  occupancy.

Function
REQ-021 head/tail are IDX_W+1 bits wide; low bits index, MSB is the wrap bit; empty = (head==tail); full = index bits equal and wrap bits differ.
REQ-022 Allocate fires when alloc_req_i && !full_o: write prd/pc/inst at tail, clear done and exc, tail+1; alloc_idx_o shows the pre-increment tail.
REQ-023 An alloc_req_i issued while full is dropped with no state change; full is evaluated on current-cycle state, so a same-cycle commit does not admit it.
REQ-024 Writeback port p fires when wb_valid_i[p] and the index is live (between head and tail): write value, set done, set exc = wb_exc_i[p]; writebacks to non-live indices are ignored.
REQ-025 Multiple ports targeting the same index in one cycle: the highest port number wins.
REQ-026 commit_valid_o = !empty_o && done[head]; the commit_* outputs are combinational from the head entry and are zero when commit_valid_o is 0.
REQ-027 Commit fires when commit_valid_o && commit_ready_i: head+1; with commit_valid_o held high, the head entry is held stable until accepted.
REQ-028 The ROB sustains one allocate, NUM_WB writebacks, and one commit in the same cycle; count_o is unchanged on a simultaneous allocate and commit.
REQ-029 A fired commit with commit_exc_o=1 raises flush_o for exactly the next cycle and performs the flush in REQ-030 at the same edge.
REQ-030 Flush (flush_i, or REQ-029): head=tail=0, all done/exc cleared, count 0; it overrides allocate and writeback in that cycle; a commit presented in that cycle still completes.
REQ-031 Pointers wrap from NUM_ENTRIES-1 to 0 with wrap-bit toggle; no entry is ever overwritten while live.

Reset
REQ-032 With reset_i high at a clock edge: head=tail=0, count_o=0, empty_o=1, full_o=0, commit_valid_o=0, flush_o=0, all done/exc bits cleared.
REQ-033 Reset overrides flush, allocate, writeback, and commit; reset mid-operation discards all entries; payload storage need not be cleared.

Verification
REQ-034 Allocate 3 (pc 0x100/0x104/0x108); writeback idx 2 then 0 then 1, commit_ready_i=1 -> commits in pc order 0x100, 0x104, 0x108, one per cycle, after idx 0 completes.
REQ-035 Fill 32 entries -> full_o=1, count_o=32; 33rd alloc_req_i is dropped, alloc_idx_o stays 0; after one commit, the next alloc gets idx 0 with the wrap bit set.
REQ-036 Ports 0 and 2 write idx 5 with 0xAAAA/0xBBBB in the same cycle -> committed value is 0xBBBB.
REQ-037 Head entry done, commit_ready_i=0 for 4 cycles -> commit_valid_o stays 1 with stable fields; ready rises -> exactly one commit.
REQ-038 Head entry written with wb_exc_i=1, then committed -> commit_exc_o=1, flush_o pulses for 1 cycle, then empty_o=1 and count_o=0; flush_i alongside alloc -> alloc ignored, ROB empty.
REQ-039 reset_i asserted with 10 live entries -> next cycle empty_o=1, commit_valid_o=0, alloc_idx_o=0.
